// File: rtl/prim_rr_onehot_arb.sv
// prim_rr_onehot_arb: round-robin arbiter with a registered one-hot grant that
//   stays locked until the consumer accepts it.
// Latency: the grant appears one cycle after the request. Handshake cycles
//   re-arbitrate at the same edge, so back-to-back grants have no bubble.
// Backpressure: while ready_i is low the grant, index and valid stay frozen,
//   whatever req_i does.
//
// Ports:
//   clk_i    sole clock, rising edge
//   rst_ni   asynchronous active-low reset
//   req_i    [N]    per-requester level request
//   gnt_o    [N]    registered one-hot grant
//   idx_o    [IdxW] registered binary index of the granted requester
//   valid_o         grant valid (equals |gnt_o)
//   ready_i         consumer accepts the current grant
//   err_o           sticky integrity error
//
// Optional macro PRIM_RR_ARB_ERR_CHK_EN adds the integrity checker behind
// err_o. Without it, err_o is tied low.
module prim_rr_onehot_arb #(
  parameter int N    = 4,
  parameter int IdxW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            err_o
);

  typedef enum logic {
    Idle = 1'b0,
    Hold = 1'b1
  } state_e;

  localparam logic [N-1:0]    OneN   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IdxW-1:0] LastIx = IdxW'(N - 1);

  state_e          state_q;
  logic [N-1:0]    gnt_q;
  logic [IdxW-1:0] idx_q;
  logic [IdxW-1:0] ptr_q;
  logic            valid_q;

  logic            hs;
  logic [IdxW-1:0] ptr_inc;
  logic [IdxW-1:0] base_ptr;
  logic            gnt_vld_d;
  logic [IdxW-1:0] idx_d;
  logic [N-1:0]    gnt_d;

  assign hs      = valid_q & ready_i;
  assign ptr_inc = (idx_q == LastIx) ? '0 : idx_q + IdxW'(1);

  // On a handshake the search must already start after the grant being
  // retired, otherwise the new grant would be computed from the stale pointer.
  assign base_ptr = hs ? ptr_inc : ptr_q;

  // First set request at base_ptr, base_ptr+1, ... wrapping at N.
  always_comb begin
    int j;
    j         = 0;
    gnt_vld_d = 1'b0;
    idx_d     = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(base_ptr) + k;
      if (j >= N) j = j - N;
      if (!gnt_vld_d && req_i[j]) begin
        gnt_vld_d = 1'b1;
        idx_d     = IdxW'(j);
      end
    end
  end

  assign gnt_d = gnt_vld_d ? (OneN << idx_d) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (gnt_vld_d) begin
            state_q <= Hold;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= 1'b1;
          end
        end
        Hold: begin
          if (ready_i) begin
            ptr_q <= ptr_inc;
            if (gnt_vld_d) begin
              gnt_q   <= gnt_d;
              idx_q   <= idx_d;
              valid_q <= 1'b1;
            end else begin
              state_q <= Idle;
              gnt_q   <= '0;
              idx_q   <= '0;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= Idle;
          gnt_q   <= '0;
          idx_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;

`ifdef PRIM_RR_ARB_ERR_CHK_EN
  logic err_q;
  logic bad;

  // state_q and valid_q are deliberately redundant so that a flipped bit in
  // either one shows up as a disagreement.
  assign bad = ((gnt_q & (gnt_q - OneN)) != '0)
             | (valid_q != (|gnt_q))
             | (gnt_q[idx_q] != valid_q)
             | ((state_q == Hold) != valid_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | bad;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/prim_rr_onehot_arb.md
PRIM_RR_ONEHOT_ARB -- requirements
Module: prim_rr_onehot_arb

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..32).
REQ-002 SHALL have parameter IdxW, default $clog2(N), meaning grant index width; N <= 2**IdxW.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_i  input  N  per-requester request, level-sensitive.
REQ-006 SHALL have port gnt_o  output  N  registered one-hot grant vector.
REQ-007 SHALL have port idx_o  output  IdxW  registered binary index of the granted requester.
REQ-008 SHALL have port valid_o  output  1  grant valid; equals OR of gnt_o.
REQ-009 SHALL have port ready_i  input  1  consumer accepts the current grant.
REQ-010 SHALL have port err_o  output  1  sticky integrity error.
REQ-011 SHALL drive gnt_o/idx_o/valid_o so they connect directly to the oh/addr/en inputs of the downstream one-hot checker (strict, address-checked).

Function
REQ-012 SHALL implement a two-state FSM: IDLE (valid_o=0) and HOLD (valid_o=1).
REQ-013 SHALL keep a round-robin pointer ptr (IdxW bits, 0..N-1) naming the highest-priority requester.
REQ-014 SHALL, in IDLE with req_i != 0, select the first set req_i bit at index ptr, ptr+1, ... wrapping N-1 -> 0, and register it into gnt_o/idx_o with valid_o=1 at the next edge (1-cycle latency), entering HOLD.
REQ-015 SHALL remain in IDLE with all outputs zero while req_i == 0.
REQ-016 SHALL, in HOLD, keep gnt_o/idx_o/valid_o stable until valid_o && ready_i, regardless of req_i changes (grant locked, including withdrawal of the granted request).
REQ-017 SHALL, on a handshake (valid_o && ready_i), set ptr = idx_o+1, wrapping N-1 -> 0.
REQ-018 SHALL, on a handshake cycle with req_i != 0, arbitrate req_i using the updated pointer (idx_o+1) and register the new grant at the same edge, staying in HOLD (back-to-back grants, no bubble).
REQ-019 SHALL, on a handshake cycle with req_i == 0, return to IDLE with gnt_o=0, idx_o=0, valid_o=0.
REQ-020 SHALL never register more than one gnt_o bit set; gnt_o[idx_o] SHALL equal valid_o.
REQ-021 SHALL ignore ready_i while in IDLE.
REQ-022 SHALL ignore req_i bits at or above index N (none exist); idx_o values >= N SHALL never be produced.

Reset
REQ-023 SHALL, on rst_ni low, asynchronously force state=IDLE, ptr=0, gnt_o=0, idx_o=0, valid_o=0, err_o=0.
REQ-024 SHALL, on reset asserted mid-HOLD, drop the pending grant with no handshake; first post-reset arbitration SHALL use ptr=0.

Configuration
REQ-025 SHALL support macro PRIM_RR_ARB_ERR_CHK_EN.
REQ-026 SHALL, with PRIM_RR_ARB_ERR_CHK_EN defined, set err_o at the edge after any cycle where gnt_o is not one-hot0, valid_o != |gnt_o, gnt_o[idx_o] != valid_o, or state/valid_o disagree; err_o SHALL stay 1 until reset.
REQ-027 SHALL, without PRIM_RR_ARB_ERR_CHK_EN, tie err_o to 0 with no checking logic.

Verification
REQ-028 SHALL verify: N=4, reset, req_i=4'b1010 at cycle 0 -> cycle 1 gnt_o=4'b0010, idx_o=1, valid_o=1.
REQ-029 SHALL verify: in HOLD with gnt_o=4'b0010, ready_i=0 for 5 cycles while req_i changes to 4'b0000 -> outputs unchanged all 5 cycles.
REQ-030 SHALL verify: req_i=4'b1111 held, ready_i=1 constantly -> idx_o sequence 0,1,2,3,0 on consecutive cycles with valid_o continuously 1.
REQ-031 SHALL verify: after handshake of idx_o=3 (ptr wraps to 0), req_i=4'b1001 -> next idx_o=0, not 3.
REQ-032 SHALL verify: rst_ni pulsed low mid-HOLD with idx_o=2 -> outputs 0 immediately, next grant for req_i=4'b1100 is idx_o=2 (ptr=0 search).
REQ-033 SHALL verify with PRIM_RR_ARB_ERR_CHK_EN: force gnt_o register to 4'b0110 for one cycle -> err_o=1 next cycle and stays 1 until reset; without macro err_o stays 0.
